pix_frame_rx: RTL and testbench
===============================

# pix_frame_rx

Upstream pixel-stream stage of the photo-frame datapath, between `uart_rx` and the frame-buffer RAM/SPRAM write port. It parses a framed image stream from received UART bytes and unpacks three-byte groups into pairs of RGB444 pixels. Each pixel is written to a linear frame-buffer address. Every block ends with a host checksum byte, answered with an ACK or NAK code for `uart_tx`; NAK rewinds the block for retransmission.

## Interface
Parameters:
- `ADDR_W`, 15: frame-buffer address width.
- `BLOCK_PIX`, 64: pixels per checksummed block. Must be even; `FRAME_PIX` must be a multiple of it.
- `FRAME_PIX`, 19200: pixels per frame (160x120).
- `HDR_BYTE`, 8'hA5: frame start byte.
- `ACK_CODE`, 8'h06; `NAK_CODE`, 8'h15: reply codes.
- `TIMEOUT_CYC`, 5_000_000: idle-byte timeout in clocks. Only used with `PIXRX_TIMEOUT_EN`.

Ports:
- `i_clk_sys` in 1: system clock, 50 MHz.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_en` in 1: reception allowed. Driven from the main state machine (image state).
- `i_rx_data` in 8: received byte. Valid when `i_rx_done` is high.
- `i_rx_done` in 1: one-cycle byte strobe from `uart_rx`.
- `o_wr_en` out 1: one-cycle pixel write strobe.
- `o_wr_addr` out `ADDR_W`: pixel write address.
- `o_wr_data` out 12: RGB444 pixel.
- `o_check_code` out 8: `ACK_CODE` or `NAK_CODE`.
- `o_check_valid` out 1: one-cycle strobe qualifying `o_check_code`.
- `o_receiving` out 1: a frame is in progress.
- `o_frame_done` out 1: one-cycle strobe when the last block is ACKed.
- `o_pix_cnt` out `ADDR_W`: count of ACKed (committed) pixels.
- `o_err` out 1: one-cycle strobe on timeout abort. Held 0 when the timeout is compiled out.

## Operation
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Counters, checksum and byte phase are 0.
- States:
  - IDLE:
    - `i_rx_done` with `i_en` and byte == `HDR_BYTE` → DATA. `o_receiving` goes 1.
    - `blk_base`, `pix_idx`, `phase` and `sum` are cleared on this transition.
    - All other bytes are ignored.
  - DATA: byte phase 0/1/2 cycles through b0, b1, b2 of each group.
    - `sum <= sum + byte` (mod 256) on every data byte.
    - Phase 0: latch b0.
    - Phase 1: write pixel `{b0, b1[7:4]}`; latch `b1[3:0]`.
    - Phase 2: write pixel `{b1[3:0], b2}`.
    - Write address is `blk_base + pix_idx`; `pix_idx` increments after each write.
    - When `pix_idx` reaches `BLOCK_PIX` → CHK.
  - CHK: the next byte is the checksum.
    - Match (`byte == sum`): emit `ACK_CODE`.
      - `blk_base += BLOCK_PIX`; `o_pix_cnt <= blk_base + BLOCK_PIX`.
      - If the new base == `FRAME_PIX`: pulse `o_frame_done`, `o_receiving` → 0, go IDLE.
      - Otherwise go to DATA.
    - Mismatch: emit `NAK_CODE`.
      - `pix_idx`, `phase` and `sum` are cleared; `blk_base` is unchanged.
      - Go to DATA. The host resends the same block, which overwrites the same addresses.
- `i_en` low in DATA or CHK:
  - Abort to IDLE, clear counters, `o_receiving` → 0.
  - No check, done or err strobe.
  - `o_pix_cnt` keeps its last value.
- `i_rx_done` is ignored in IDLE when `i_en` is 0.
- `o_wr_addr` and `o_wr_data` hold their last values between strobes.

## Timing
- All outputs are registered.
- Pixel write latency: `o_wr_en` is high exactly 1 cycle after the `i_rx_done` of b1 or b2.
- Check latency: `o_check_valid` is high 1 cycle after the checksum byte's `i_rx_done`. `o_frame_done` coincides with the final ACK strobe.
- There is no dead cycle between states. A byte arriving on the cycle after a check strobe is processed normally.
- Abort on `i_en` low: `o_receiving` is 0 on the following cycle.
- Asynchronous reset mid-frame: all outputs drop to 0 immediately. Any in-flight strobe is lost.
- Checksum width is 8 bits, wrap-around. The pixel index never exceeds `BLOCK_PIX`, and the address never exceeds `FRAME_PIX-1`.

## Configuration
- `PIXRX_TIMEOUT_EN` defined:
  - A counter is reloaded on each `i_rx_done` while in DATA or CHK.
  - When it reaches `TIMEOUT_CYC` with no byte: pulse `o_err`, abort to IDLE (as for `i_en` low), `o_receiving` → 0.
- Not defined: no counter is built, the block waits indefinitely, and `o_err` is tied 0.

## Test plan
Bench parameters: `BLOCK_PIX`=4, `FRAME_PIX`=8, `TIMEOUT_CYC`=1000.
- Good frame:
  - `i_en`=1; send A5, 12 34 56 78 9A BC 6A.
  - Expect writes (addr, data): (0,123) (1,456) (2,789) (3,ABC). Then check 06 and `o_pix_cnt`=4.
  - Repeat the same 7 bytes. Expect addresses 4..7, check 06 with `o_frame_done` in the same cycle, `o_receiving`=0.
- Bad checksum:
  - After A5 + 6 data bytes, send 00. Expect check 15 and `o_pix_cnt`=0.
  - Resend the block with 6A. Expect rewrites of addresses 0..3, then 06.
- Header filtering: send 11 22 A5 with `i_en`=0, then 33 A5 with `i_en`=1. Expect no writes; `o_receiving` rises only after the second A5.
- Abort: drop `i_en` after 4 data bytes. Expect `o_receiving`=0 the next cycle and no check strobe. A new A5 plus block writes from address 0.
- Async reset: assert `i_rst` mid-block between clock edges. Expect all outputs 0 before the next edge; IDLE after release.
- Timeout (macro on): stall 1000 cycles after 2 data bytes. Expect one `o_err` pulse, `o_receiving`=0. Macro off: no pulse.

Source files
------------

// File: rtl/pix_frame_rx.sv
// pix_frame_rx: parses a framed UART byte stream into RGB444 pixel writes with per-block ACK/NAK.
// Optional idle-byte timeout abort is built when PIXRX_TIMEOUT_EN is defined.
module pix_frame_rx #(
   parameter int         ADDR_W      = 15,
   parameter int         BLOCK_PIX   = 64,
   parameter int         FRAME_PIX   = 19200,
   parameter logic [7:0] HDR_BYTE    = 8'hA5,
   parameter logic [7:0] ACK_CODE    = 8'h06,
   parameter logic [7:0] NAK_CODE    = 8'h15,
   parameter int         TIMEOUT_CYC = 5_000_000
) (
   input  logic              i_clk_sys,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_done,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [11:0]       o_wr_data,
   output logic [7:0]        o_check_code,
   output logic              o_check_valid,
   output logic              o_receiving,
   output logic              o_frame_done,
   output logic [ADDR_W-1:0] o_pix_cnt,
   output logic              o_err
);

   // state | meaning
   // IDLE  | waiting for HDR_BYTE, all other bytes dropped
   // DATA  | unpacking 3-byte groups into pixel pairs
   // CHK   | next byte is the block checksum
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CHK  = 2'd2
   } state_t;

   localparam int PIX_W = $clog2(BLOCK_PIX + 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] blk_base_q, blk_base_d;
   logic [PIX_W-1:0]  pix_idx_q, pix_idx_d;
   logic [1:0]        phase_q, phase_d;
   logic [7:0]        sum_q, sum_d;
   logic [7:0]        b0_q, b0_d;
   logic [3:0]        b1_lo_q, b1_lo_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [11:0]       wr_data_q, wr_data_d;
   logic [7:0]        check_code_q, check_code_d;
   logic              check_valid_q, check_valid_d;
   logic              receiving_q, receiving_d;
   logic              frame_done_q, frame_done_d;
   logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
   logic              err_q, err_d;

   logic              tmo_hit;
   logic [ADDR_W-1:0] blk_next;
   logic [PIX_W-1:0]  pix_next;
   logic [ADDR_W-1:0] wr_addr_now;

`ifdef PIXRX_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;

   // down-counter reloaded on every byte; parked at the load value while idle
   always_comb begin
      tmo_d = tmo_q;
      if (state_q == IDLE || i_rx_done) begin
         tmo_d = TMO_LOAD;
      end else if (tmo_q != '0) begin
         tmo_d = tmo_q - TMO_W'(1);
      end
   end

   always_ff @(posedge i_clk_sys or posedge i_rst) begin
      if (i_rst) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end

   assign tmo_hit = (state_q != IDLE) && (tmo_q == '0) && !i_rx_done;
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CYC != 0);
   assign tmo_hit    = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      blk_base_d    = blk_base_q;
      pix_idx_d     = pix_idx_q;
      phase_d       = phase_q;
      sum_d         = sum_q;
      b0_d          = b0_q;
      b1_lo_d       = b1_lo_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      check_code_d  = check_code_q;
      check_valid_d = 1'b0;
      receiving_d   = receiving_q;
      frame_done_d  = 1'b0;
      pix_cnt_d     = pix_cnt_q;
      err_d         = 1'b0;
      blk_next      = blk_base_q + ADDR_W'(BLOCK_PIX);
      pix_next      = pix_idx_q + PIX_W'(1);
      wr_addr_now   = blk_base_q + ADDR_W'(pix_idx_q);

      if (state_q != IDLE && (!i_en || tmo_hit)) begin
         // abort keeps the committed pixel count; only a timeout reports an error
         state_d     = IDLE;
         blk_base_d  = '0;
         pix_idx_d   = '0;
         phase_d     = '0;
         sum_d       = '0;
         receiving_d = 1'b0;
         err_d       = i_en && tmo_hit;
      end else if (i_rx_done) begin
         case (state_q)
            IDLE: begin
               if (i_en && i_rx_data == HDR_BYTE) begin
                  state_d     = DATA;
                  blk_base_d  = '0;
                  pix_idx_d   = '0;
                  phase_d     = '0;
                  sum_d       = '0;
                  receiving_d = 1'b1;
               end
            end
            DATA: begin
               sum_d = sum_q + i_rx_data;
               case (phase_q)
                  2'd0: begin
                     b0_d    = i_rx_data;
                     phase_d = 2'd1;
                  end
                  2'd1: begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = wr_addr_now;
                     wr_data_d = {b0_q, i_rx_data[7:4]};
                     b1_lo_d   = i_rx_data[3:0];
                     pix_idx_d = pix_next;
                     phase_d   = 2'd2;
                  end
                  2'd2: begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = wr_addr_now;
                     wr_data_d = {b1_lo_q, i_rx_data};
                     pix_idx_d = pix_next;
                     phase_d   = 2'd0;
                     if (pix_next == PIX_W'(BLOCK_PIX)) begin
                        state_d = CHK;
                     end
                  end
                  default: phase_d = 2'd0;
               endcase
            end
            CHK: begin
               check_valid_d = 1'b1;
               pix_idx_d     = '0;
               phase_d       = '0;
               sum_d         = '0;
               state_d       = DATA;
               if (i_rx_data == sum_q) begin
                  check_code_d = ACK_CODE;
                  blk_base_d   = blk_next;
                  pix_cnt_d    = blk_next;
                  if (blk_next == ADDR_W'(FRAME_PIX)) begin
                     frame_done_d = 1'b1;
                     receiving_d  = 1'b0;
                     blk_base_d   = '0;
                     state_d      = IDLE;
                  end
               end else begin
                  check_code_d = NAK_CODE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk_sys or posedge i_rst) begin
      if (i_rst) begin
         state_q       <= IDLE;
         blk_base_q    <= '0;
         pix_idx_q     <= '0;
         phase_q       <= '0;
         sum_q         <= '0;
         b0_q          <= '0;
         b1_lo_q       <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         check_code_q  <= '0;
         check_valid_q <= 1'b0;
         receiving_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         pix_cnt_q     <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         blk_base_q    <= blk_base_d;
         pix_idx_q     <= pix_idx_d;
         phase_q       <= phase_d;
         sum_q         <= sum_d;
         b0_q          <= b0_d;
         b1_lo_q       <= b1_lo_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         check_code_q  <= check_code_d;
         check_valid_q <= check_valid_d;
         receiving_q   <= receiving_d;
         frame_done_q  <= frame_done_d;
         pix_cnt_q     <= pix_cnt_d;
         err_q         <= err_d;
      end
   end

   assign o_wr_en       = wr_en_q;
   assign o_wr_addr     = wr_addr_q;
   assign o_wr_data     = wr_data_q;
   assign o_check_code  = check_code_q;
   assign o_check_valid = check_valid_q;
   assign o_receiving   = receiving_q;
   assign o_frame_done  = frame_done_q;
   assign o_pix_cnt     = pix_cnt_q;
   assign o_err         = err_q;

endmodule

// File: tb/tb_pix_frame_rx.sv
// Directed + randomized bench for pix_frame_rx against a byte-level frame model.
// Timeout expectations follow whether PIXRX_TIMEOUT_EN is defined.
module tb_pix_frame_rx;
   localparam int ADDR_W      = 15;
   localparam int BLOCK_PIX   = 4;
   localparam int FRAME_PIX   = 8;
   localparam int TIMEOUT_CYC = 1000;
   localparam logic [7:0] HDR = 8'hA5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_done = 1'b0;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [11:0]       wr_data;
   logic [7:0]        check_code;
   logic              check_valid;
   logic              receiving;
   logic              frame_done;
   logic [ADDR_W-1:0] pix_cnt;
   logic              err;

   pix_frame_rx #(
      .ADDR_W(ADDR_W), .BLOCK_PIX(BLOCK_PIX), .FRAME_PIX(FRAME_PIX),
      .HDR_BYTE(8'hA5), .ACK_CODE(8'h06), .NAK_CODE(8'h15), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .i_clk_sys(clk), .i_rst(rst), .i_en(en), .i_rx_data(rx_data), .i_rx_done(rx_done),
      .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
      .o_check_code(check_code), .o_check_valid(check_valid), .o_receiving(receiving),
      .o_frame_done(frame_done), .o_pix_cnt(pix_cnt), .o_err(err)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int err_pulses = 0;
   int chk_seen = 0;
   int exp_pix_cnt = 0;

   typedef struct { int addr; int data; } wr_t;
   wr_t wr_q[$];

   always @(negedge clk) begin
      if (wr_en === 1'b1) wr_q.push_back('{int'(wr_addr), int'(wr_data)});
      if (check_valid === 1'b1) chk_seen++;
      if (err === 1'b1) err_pulses++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // pixel k of a block as the spec's byte-pair arithmetic defines it
   function automatic int model_pix(input logic [7:0] d[$], input int k);
      int g = k / 2;
      if (k % 2 == 0) return int'(d[3*g]) * 16 + int'(d[3*g+1]) / 16;
      return (int'(d[3*g+1]) % 16) * 256 + int'(d[3*g+2]);
   endfunction

   task automatic all_zero(input string tag);
      chk({tag, " wr_en"}, 32'(wr_en), 32'd0);
      chk({tag, " wr_addr"}, 32'(wr_addr), 32'd0);
      chk({tag, " wr_data"}, 32'(wr_data), 32'd0);
      chk({tag, " check_code"}, 32'(check_code), 32'd0);
      chk({tag, " check_valid"}, 32'(check_valid), 32'd0);
      chk({tag, " receiving"}, 32'(receiving), 32'd0);
      chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, " pix_cnt"}, 32'(pix_cnt), 32'd0);
      chk({tag, " err"}, 32'(err), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; rx_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_pix_cnt = 0;
      @(negedge clk);
   endtask

   // called at (or just after) a falling edge; exp_wr < 0 skips the latency check
   task automatic send_byte(input logic [7:0] b, input int gap, input int exp_wr);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      if (exp_wr >= 0) chk("wr_latency", 32'(wr_en), 32'(exp_wr));
      repeat (gap) @(negedge clk);
   endtask

   function automatic void rand_block(output logic [7:0] d[$]);
      d = {};
      for (int i = 0; i < BLOCK_PIX * 3 / 2; i++) d.push_back(8'($urandom_range(0, 255)));
   endfunction

   // cs_mode: -1 correct checksum, -2 random wrong checksum, >=0 explicit byte
   task automatic send_block(input logic [7:0] d[$], input int base, input int cs_mode, input string tag);
      logic [7:0] cs;
      logic [7:0] cs_tx;
      bit         ack;
      bit         done;
      #1;
      wr_q.delete();
      chk_seen = 0;
      cs = 8'h00;
      foreach (d[i]) cs = cs + d[i];
      for (int i = 0; i < d.size(); i++) send_byte(d[i], $urandom_range(0, 2), (i % 3 == 0) ? 0 : 1);
      if (cs_mode == -1)      cs_tx = cs;
      else if (cs_mode == -2) cs_tx = cs + 8'($urandom_range(1, 255));
      else                    cs_tx = 8'(cs_mode);
      ack  = (cs_tx == cs);
      done = ack && (base + BLOCK_PIX == FRAME_PIX);
      if (ack) exp_pix_cnt = base + BLOCK_PIX;
      rx_data = cs_tx;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      chk({tag, " check_valid"}, 32'(check_valid), 32'd1);
      chk({tag, " check_code"}, 32'(check_code), ack ? 32'h06 : 32'h15);
      chk({tag, " frame_done"}, 32'(frame_done), 32'(done));
      chk({tag, " pix_cnt"}, 32'(pix_cnt), 32'(exp_pix_cnt));
      chk({tag, " receiving"}, 32'(receiving), done ? 32'd0 : 32'd1);
      #1;
      chk({tag, " n_writes"}, 32'(wr_q.size()), 32'(BLOCK_PIX));
      for (int k = 0; k < wr_q.size() && k < BLOCK_PIX; k++) begin
         chk({tag, " wr_addr"}, 32'(wr_q[k].addr), 32'(base + k));
         chk({tag, " wr_data"}, 32'(wr_q[k].data), 32'(model_pix(d, k)));
      end
      chk({tag, " addr_hold"}, 32'(wr_addr), 32'(base + BLOCK_PIX - 1));
      chk({tag, " n_checks"}, 32'(chk_seen), 32'd1);
   endtask

   initial begin
      logic [7:0] fixed[$];
      logic [7:0] d[$];
      fixed = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

      // reset values
      @(negedge clk);
      all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // good two-block frame
      en = 1'b1;
      send_byte(HDR, 0, 0);
      chk("hdr receiving", 32'(receiving), 32'd1);
      send_block(fixed, 0, -1, "good_blk0");
      chk("good px0", 32'(wr_q[0].data), 32'h123);
      chk("good px3", 32'(wr_q[3].data), 32'hABC);
      send_block(fixed, BLOCK_PIX, -1, "good_blk1");

      // bad checksum then retransmission
      do_reset();
      en = 1'b1;
      send_byte(HDR, 1, 0);
      send_block(fixed, 0, 0, "nak_blk");
      send_block(fixed, 0, -1, "resend_blk");

      // header filtering
      do_reset();
      #1 wr_q.delete();
      en = 1'b0;
      send_byte(8'h11, 0, 0);
      send_byte(8'h22, 0, 0);
      send_byte(HDR, 1, 0);
      chk("filter en0 receiving", 32'(receiving), 32'd0);
      en = 1'b1;
      send_byte(8'h33, 1, 0);
      chk("filter 33 receiving", 32'(receiving), 32'd0);
      send_byte(HDR, 0, 0);
      chk("filter A5 receiving", 32'(receiving), 32'd1);
      #1 chk("filter n_writes", 32'(wr_q.size()), 32'd0);

      // abort after 4 data bytes
      chk_seen = 0;
      err_pulses = 0;
      rand_block(d);
      for (int i = 0; i < 4; i++) send_byte(d[i], 0, (i % 3 == 0) ? 0 : 1);
      en = 1'b0;
      @(negedge clk);
      chk("abort receiving", 32'(receiving), 32'd0);
      repeat (3) @(negedge clk);
      #1;
      chk("abort n_checks", 32'(chk_seen), 32'd0);
      chk("abort err", 32'(err_pulses), 32'd0);
      chk("abort n_writes", 32'(wr_q.size()), 32'd2);
      chk("abort pix_cnt", 32'(pix_cnt), 32'd0);
      en = 1'b1;
      send_byte(HDR, 0, 0);
      rand_block(d);
      send_block(d, 0, -1, "after_abort");

      // randomized frames with random NAK/retransmit
      do_reset();
      en = 1'b1;
      for (int f = 0; f < 4; f++) begin
         send_byte(HDR, 0, 0);
         chk("rand hdr receiving", 32'(receiving), 32'd1);
         for (int b = 0; b < FRAME_PIX / BLOCK_PIX; b++) begin
            rand_block(d);
            if ($urandom_range(0, 2) == 0) send_block(d, b * BLOCK_PIX, -2, "rand_nak");
            send_block(d, b * BLOCK_PIX, -1, "rand_ack");
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // asynchronous reset mid-block with a write strobe in flight
      do_reset();
      en = 1'b1;
      send_byte(HDR, 0, 0);
      rand_block(d);
      send_block(d, 0, -1, "pre_rst");
      send_byte(8'h5C, 0, 0);
      rx_data = 8'hE7;
      rx_done = 1'b1;
      @(posedge clk);
      #3;
      rst = 1'b1;
      rx_done = 1'b0;
      #1;
      all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      exp_pix_cnt = 0;
      @(negedge clk);
      send_byte(8'h12, 0, 0);
      chk("post_rst idle", 32'(receiving), 32'd0);
      send_byte(HDR, 0, 0);
      chk("post_rst hdr", 32'(receiving), 32'd1);
      rand_block(d);
      send_block(d, 0, -1, "post_rst_blk");

      // idle-byte timeout
      do_reset();
      en = 1'b1;
      send_byte(HDR, 0, 0);
      send_byte(8'h3C, 0, 0);
      send_byte(8'hC3, 0, 1);
      #1 err_pulses = 0;
      repeat (TIMEOUT_CYC + 100) @(negedge clk);
      #1;
`ifdef PIXRX_TIMEOUT_EN
      chk("timeout err_pulses", 32'(err_pulses), 32'd1);
      chk("timeout receiving", 32'(receiving), 32'd0);
`else
      chk("timeout err_pulses", 32'(err_pulses), 32'd0);
      chk("timeout receiving", 32'(receiving), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
